ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Consumes the single-cycle scan-code strobes produced by the PS/2 keyboard receiver (`scanCode`/`scanCodeReady`) and turns Scan Code Set 2 byte sequences into complete key events. Each event carries a make/break flag, an extended flag, the raw code and a US-layout ASCII translation. Events are buffered in a small FIFO behind a valid/ready handshake for the CPU-side keyboard port. The decoder also tracks Shift/Ctrl/Caps Lock and exports their state.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two and ≥ 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `scanCode` in 8: byte from the receiver; valid only while `scanCodeReady` is high.
- `scanCodeReady` in 1: one-cycle strobe, one per received byte; never high on consecutive cycles.
- `keyValid` out 1: the FIFO head holds an event.
- `keyReady` in 1: consumer accepts the head event.
- `keyAscii` out 8: ASCII of the head event, or 0x00 if the key has no mapping.
- `keyCode` out 8: raw make code of the head event, without prefixes.
- `keyExtended` out 1: the head event was E0-prefixed.
- `keyRelease` out 1: the head event is a break (release).
- `shiftHeld`, `ctrlHeld`, `capsLock` out 1 each: current modifier state.
- `overflow` out 1: sticky; set when an event is dropped. Cleared only by reset.

## Operation
- **Prefix FSM.** States IDLE, GOT_E0, GOT_F0, GOT_E0F0. The FSM advances only on a `scanCodeReady` strobe.
  - IDLE: E0 → GOT_E0. F0 → GOT_F0. Any other byte emits a make event with ext=0 and stays in IDLE.
  - GOT_E0: F0 → GOT_E0F0. E0 → stays in GOT_E0. Any other byte emits a make event with ext=1 → IDLE.
  - GOT_F0: E0 → GOT_E0 (resync). F0 → stays in GOT_F0. Any other byte emits a break event with ext=0 → IDLE.
  - GOT_E0F0: E0 → GOT_E0. F0 → stays in GOT_E0F0. Any other byte emits a break event with ext=1 → IDLE.
- **Discarded bytes.** 0x00, 0xFF, 0xAA, 0xFA, 0xFE and 0xE1 are dropped in every state, produce no event and force the FSM to IDLE.
- **Modifier tracking.**
  - `shiftHeld` = left Shift (0x12) OR right Shift (0x59) held. Each is tracked separately; ext=0 only.
  - `ctrlHeld` = 0x14 held, with either ext value; left and right are tracked separately.
  - `capsLock` toggles on a 0x58 make only if Caps was previously released. Typematic repeats do not toggle it; an internal capsDown bit tracks this.
  - Modifier keys still emit events, with ascii 0x00.
- **ASCII translation** is computed from the modifier state before the current event updates it.
  - Letters: lowercase; uppercase when shift XOR caps. With ctrl, the value is the uppercase code & 0x1F.
  - Digits row: unshifted digits; with shift, US symbols `)!@#$%^&*(`.
  - Fixed codes: space 0x29 → 0x20, Enter 0x5A → 0x0D (also for E0 5A), Backspace 0x66 → 0x08, Tab 0x0D → 0x09, Esc 0x76 → 0x1B.
  - Everything else, and all other extended codes, → 0x00.
  - Break events carry the same ascii their make event would have.
- **FIFO.**
  - An emitted event is pushed. The head entry drives the key outputs.
  - A pop occurs when `keyValid && keyReady`.
  - Push while full with no pop: the event is dropped and `overflow` is set; FIFO contents are unchanged.
  - Push while full with a simultaneous pop: both occur and the count is unchanged.
  - `keyReady` while empty has no effect.

## Timing
- **Reset values.** All outputs are 0. The FSM is in IDLE, the FIFO is empty, and all modifier and capsDown bits are 0.
- **Latency.** A strobe at cycle N updates the FSM, modifiers and FIFO at the next edge. `keyValid` is high from cycle N+1 onward (1-cycle latency). Modifier outputs change at the same edge.
- **Output stability.** Head outputs are stable while `keyValid && !keyReady`. After a pop, the next entry appears the following cycle; there is no bubble if further entries exist.
- **Reset mid-sequence.** A reset between E0/F0 and the final byte abandons the sequence. The next byte is parsed from IDLE.
- **Don't-care outputs.** Head outputs are don't-care while `keyValid` = 0. Benches check them only while valid.

## Structure
- **Package `ps2_kbd_pkg`** holds:
  - the state enum;
  - byte constants: E0, F0, E1, AA, FA, FE, 00, FF, and the modifier codes;
  - `key_event_t` struct {ascii, code, extended, release};
  - the pure function `to_ascii(code, ext, shift, caps, ctrl)` containing the translation table.
- **Sub-module `key_event_fifo`**: a parameterised synchronous FIFO of `key_event_t` with push/pop/full/empty, using the same clock and reset.
- **Top level**: the FSM, the modifier registers and the `overflow` flag.

## Test plan
- Bytes 1C, F0 1C → two events: {0x61, 1C, ext0, make} then {0x61, 1C, ext0, release}. `keyValid` rises 1 cycle after the first strobe.
- 12, 1C, F0 12 → `shiftHeld` goes 1 then 0. The 1C event has ascii 0x41.
- 58, 58, F0 58, 1C → `capsLock` = 1 (the repeated make does not toggle it). The 1C event has ascii 0x41. Then 58 → `capsLock` = 0.
- E0 75, E0 F0 75 → events {0x00, 75, ext1, make} and {0x00, 75, ext1, release}. E0 5A gives ascii 0x0D with ext1.
- 14 then 21 → ascii 0x03. Bytes FA, AA and 00 between keys produce no events and do not disturb the sequence.
- With `keyReady` = 0, push FIFO_DEPTH + 1 makes → only the first FIFO_DEPTH events are retained and `overflow` = 1. Push while full with `keyReady` = 1 in the same cycle → accepted and `overflow` is unchanged. Reset after E0 → the next byte 16 yields ext0 ascii 0x31.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 Scan Code Set 2 key decoder.
//   state_t      : prefix FSM states
//   key_event_t  : one decoded key event {ascii, code, extended, is_release}
//   is_discard() : bytes that carry no key information (ACK, BAT, errors, E1)
//   to_ascii()   : US-layout translation of a make code under modifier state
package ps2_kbd_pkg;

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;
  localparam logic [7:0] BYTE_AA = 8'hAA;
  localparam logic [7:0] BYTE_FA = 8'hFA;
  localparam logic [7:0] BYTE_FE = 8'hFE;
  localparam logic [7:0] BYTE_00 = 8'h00;
  localparam logic [7:0] BYTE_FF = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_CAPS   = 8'h58;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;

  // 'release' is a reserved word, hence is_release.
  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] code;
    logic       extended;
    logic       is_release;
  } key_event_t;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == BYTE_00) || (b == BYTE_FF) || (b == BYTE_AA) ||
           (b == BYTE_FA) || (b == BYTE_FE) || (b == BYTE_E1);
  endfunction

  function automatic logic [7:0] to_ascii(input logic [7:0] code,
                                          input logic       ext,
                                          input logic       shift,
                                          input logic       caps,
                                          input logic       ctrl);
    logic [7:0] letter, digit, sym, r;
    letter = 8'h00;
    digit  = 8'h00;
    sym    = 8'h00;
    r      = 8'h00;
    case (code)
      8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
      8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
      8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
      8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
      8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
      8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
      8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
      8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
      8'h35: letter = "y";  8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
    case (code)
      8'h16: begin digit = "1"; sym = "!"; end
      8'h1E: begin digit = "2"; sym = "@"; end
      8'h26: begin digit = "3"; sym = "#"; end
      8'h25: begin digit = "4"; sym = "$"; end
      8'h2E: begin digit = "5"; sym = "%"; end
      8'h36: begin digit = "6"; sym = "^"; end
      8'h3D: begin digit = "7"; sym = "&"; end
      8'h3E: begin digit = "8"; sym = "*"; end
      8'h46: begin digit = "9"; sym = "("; end
      8'h45: begin digit = "0"; sym = ")"; end
      default: begin digit = 8'h00; sym = 8'h00; end
    endcase
    if (ext)
      r = (code == KEY_ENTER) ? 8'h0D : 8'h00;
    else if (letter != 8'h00) begin
      // Ctrl wins over shift/caps: control codes come from the uppercase form.
      if (ctrl)              r = (letter - 8'h20) & 8'h1F;
      else if (shift ^ caps) r = letter - 8'h20;
      else                   r = letter;
    end else if (digit != 8'h00)
      r = shift ? sym : digit;
    else begin
      case (code)
        8'h29:     r = 8'h20;
        KEY_ENTER: r = 8'h0D;
        8'h66:     r = 8'h08;
        8'h0D:     r = 8'h09;
        8'h76:     r = 8'h1B;
        default:   r = 8'h00;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous FIFO of key events.
//   push/wdata : write an event (ignored when full unless popping the same cycle)
//   pop        : remove the head (ignored when empty)
//   rdata      : head entry; reads as zero after reset
//   full/empty : occupancy flags
module key_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  key_event_t wdata,
  input  logic       pop,
  output key_event_t rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  key_event_t    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being written is the head slot being vacated.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan Code Set 2 decoder: turns receiver byte strobes into key events.
//   scanCode/scanCodeReady : byte strobe from the PS/2 receiver
//   keyValid/keyReady      : event FIFO handshake toward the CPU
//   keyAscii/keyCode/keyExtended/keyRelease : head event fields
//   shiftHeld/ctrlHeld/capsLock : live modifier state
//   overflow               : sticky, an event was dropped on a full FIFO
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scanCode,
  input  logic       scanCodeReady,
  output logic       keyValid,
  input  logic       keyReady,
  output logic [7:0] keyAscii,
  output logic [7:0] keyCode,
  output logic       keyExtended,
  output logic       keyRelease,
  output logic       shiftHeld,
  output logic       ctrlHeld,
  output logic       capsLock,
  output logic       overflow
);
  state_t     state, state_nx;
  logic       emit, ev_ext, ev_rel;
  logic       lshift, rshift, lctrl, rctrl, caps_lock, caps_down, ovf;
  logic       full, empty, pop;
  key_event_t ev, head;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state: E0 always lands in GOT_E0; F0 keeps any pending E0.
  always_comb begin
    state_nx = state;
    if (scanCodeReady) begin
      if (is_discard(scanCode))     state_nx = IDLE;
      else if (scanCode == BYTE_E0) state_nx = GOT_E0;
      else if (scanCode == BYTE_F0)
        state_nx = (state == GOT_E0 || state == GOT_E0F0) ? GOT_E0F0 : GOT_F0;
      else                          state_nx = IDLE;
    end
  end

  // Outputs: a non-prefix, non-discard byte completes an event.
  always_comb begin
    emit   = 1'b0;
    ev_ext = 1'b0;
    ev_rel = 1'b0;
    if (scanCodeReady && !is_discard(scanCode) &&
        scanCode != BYTE_E0 && scanCode != BYTE_F0) begin
      emit   = 1'b1;
      ev_ext = (state == GOT_E0) || (state == GOT_E0F0);
      ev_rel = (state == GOT_F0) || (state == GOT_E0F0);
    end
  end

  assign shiftHeld = lshift | rshift;
  assign ctrlHeld  = lctrl | rctrl;
  assign capsLock  = caps_lock;
  assign overflow  = ovf;

  // Translation uses the modifier state from before this event.
  always_comb begin
    ev.ascii      = to_ascii(scanCode, ev_ext, shiftHeld, caps_lock, ctrlHeld);
    ev.code       = scanCode;
    ev.extended   = ev_ext;
    ev.is_release = ev_rel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
      caps_lock <= 1'b0;
      caps_down <= 1'b0;
    end else if (emit) begin
      if (!ev_ext && scanCode == KEY_LSHIFT) lshift <= !ev_rel;
      if (!ev_ext && scanCode == KEY_RSHIFT) rshift <= !ev_rel;
      if (!ev_ext && scanCode == KEY_CTRL)   lctrl  <= !ev_rel;
      if ( ev_ext && scanCode == KEY_CTRL)   rctrl  <= !ev_rel;
      if (!ev_ext && scanCode == KEY_CAPS) begin
        // Typematic repeats arrive with caps_down already set.
        caps_down <= !ev_rel;
        if (!ev_rel && !caps_down) caps_lock <= !caps_lock;
      end
    end
  end

  assign keyValid = !empty;
  assign pop      = keyValid && keyReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     ovf <= 1'b0;
    else if (emit && full && !pop) ovf <= 1'b1;
  end

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (emit),
    .wdata (ev),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign keyAscii    = head.ascii;
  assign keyCode     = head.code;
  assign keyExtended = head.extended;
  assign keyRelease  = head.is_release;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a byte/expectation table driven through the
// receiver strobe, a scoreboard queue of expected events checked whenever
// the head is consumed, plus hand sequences for FIFO full/overflow and reset.
module tb_ps2_key_decoder;
  import ps2_kbd_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] scanCode = 8'h00;
  logic       scanCodeReady = 1'b0;
  logic       keyValid, keyReady;
  logic [7:0] keyAscii, keyCode;
  logic       keyExtended, keyRelease, shiftHeld, ctrlHeld, capsLock, overflow;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .scanCode(scanCode), .scanCodeReady(scanCodeReady),
    .keyValid(keyValid), .keyReady(keyReady), .keyAscii(keyAscii),
    .keyCode(keyCode), .keyExtended(keyExtended), .keyRelease(keyRelease),
    .shiftHeld(shiftHeld), .ctrlHeld(ctrlHeld), .capsLock(capsLock),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic [7:0] asc;
    logic       ext;
    logic       rel;
    logic [2:0] mods;  // {shift, ctrl, caps} after the byte
  } vec_t;

  vec_t       tbl[$];
  key_event_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int seen  = 0;

  function automatic vec_t mk(input logic [7:0] b, input logic ev, input logic [7:0] asc,
                              input logic ext, input logic rel, input logic [2:0] mods);
    vec_t v;
    v.b = b; v.ev = ev; v.asc = asc; v.ext = ext; v.rel = rel; v.mods = mods;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Head consumed at the next edge whenever valid && ready now.
  task automatic consume();
    key_event_t e;
    if (keyValid && keyReady) begin
      seen++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_event: got code %0h expected none", keyCode);
      end else begin
        e = exp_q.pop_front();
        check("event", {14'd0, keyAscii, keyCode, keyExtended, keyRelease}, {14'd0, e});
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    consume();
  endtask

  task automatic send(input logic [7:0] b);
    scanCode = b; scanCodeReady = 1'b1;
    step();
    scanCodeReady = 1'b0;
    step();
  endtask

  task automatic expect_ev(input logic [7:0] asc, input logic [7:0] code,
                           input logic ext, input logic rel);
    exp_q.push_back('{ascii: asc, code: code, extended: ext, is_release: rel});
  endtask

  initial begin
    int n0;
    keyReady = 1'b1;

    //      byte   ev  ascii  ext rel  {sh,ct,cp}
    tbl.push_back(mk(8'h1C, 1, 8'h61, 0, 0, 3'b000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'h1C, 1, 8'h61, 0, 1, 3'b000));
    tbl.push_back(mk(8'h12, 1, 8'h00, 0, 0, 3'b100));
    tbl.push_back(mk(8'h1C, 1, 8'h41, 0, 0, 3'b100));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b100));
    tbl.push_back(mk(8'h12, 1, 8'h00, 0, 1, 3'b000));
    tbl.push_back(mk(8'h58, 1, 8'h00, 0, 0, 3'b001));
    tbl.push_back(mk(8'h58, 1, 8'h00, 0, 0, 3'b001));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b001));
    tbl.push_back(mk(8'h58, 1, 8'h00, 0, 1, 3'b001));
    tbl.push_back(mk(8'h1C, 1, 8'h41, 0, 0, 3'b001));
    tbl.push_back(mk(8'h58, 1, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'h58, 1, 8'h00, 0, 1, 3'b000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'h75, 1, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'h75, 1, 8'h00, 1, 1, 3'b000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'h5A, 1, 8'h0D, 1, 0, 3'b000));
    tbl.push_back(mk(8'h14, 1, 8'h00, 0, 0, 3'b010));
    tbl.push_back(mk(8'hFA, 0, 8'h00, 0, 0, 3'b010));
    tbl.push_back(mk(8'h21, 1, 8'h03, 0, 0, 3'b010));
    tbl.push_back(mk(8'hAA, 0, 8'h00, 0, 0, 3'b010));
    tbl.push_back(mk(8'h00, 0, 8'h00, 0, 0, 3'b010));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b010));
    tbl.push_back(mk(8'h14, 1, 8'h00, 0, 1, 3'b000));
    tbl.push_back(mk(8'h59, 1, 8'h00, 0, 0, 3'b100));
    tbl.push_back(mk(8'h16, 1, 8'h21, 0, 0, 3'b100));
    tbl.push_back(mk(8'h1E, 1, 8'h40, 0, 0, 3'b100));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b100));
    tbl.push_back(mk(8'h59, 1, 8'h00, 0, 1, 3'b000));
    tbl.push_back(mk(8'h45, 1, 8'h30, 0, 0, 3'b000));
    // Discard byte abandons a pending E0.
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'hFA, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'h75, 1, 8'h00, 0, 0, 3'b000));
    // F0 then E0 resyncs to an extended make.
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'h75, 1, 8'h00, 1, 0, 3'b000));
    tbl.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b000));
    tbl.push_back(mk(8'h5A, 1, 8'h0D, 1, 1, 3'b000));
    // Shift and caps cancel for letters.
    tbl.push_back(mk(8'h58, 1, 8'h00, 0, 0, 3'b001));
    tbl.push_back(mk(8'h12, 1, 8'h00, 0, 0, 3'b101));
    tbl.push_back(mk(8'h1C, 1, 8'h61, 0, 0, 3'b101));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b101));
    tbl.push_back(mk(8'h12, 1, 8'h00, 0, 1, 3'b001));
    tbl.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 3'b001));
    tbl.push_back(mk(8'h58, 1, 8'h00, 0, 1, 3'b001));
    tbl.push_back(mk(8'h29, 1, 8'h20, 0, 0, 3'b001));
    tbl.push_back(mk(8'h66, 1, 8'h08, 0, 0, 3'b001));
    tbl.push_back(mk(8'h0D, 1, 8'h09, 0, 0, 3'b001));
    tbl.push_back(mk(8'h76, 1, 8'h1B, 0, 0, 3'b001));
    tbl.push_back(mk(8'h58, 1, 8'h00, 0, 0, 3'b000));

    // Reset state
    step(); step();
    check("reset_outputs",
          {8'd0, keyValid, keyAscii, keyCode, keyExtended, keyRelease,
           shiftHeld, ctrlHeld, capsLock, overflow}, 32'd0);
    rst = 1'b1;
    step();

    // Table: one event (or none) must appear exactly one cycle after each strobe.
    foreach (tbl[i]) begin
      n0 = seen;
      if (tbl[i].ev) expect_ev(tbl[i].asc, tbl[i].b, tbl[i].ext, tbl[i].rel);
      scanCode = tbl[i].b; scanCodeReady = 1'b1;
      step();
      check($sformatf("vec%0d_latency", i), seen - n0, {31'd0, tbl[i].ev});
      check($sformatf("vec%0d_mods", i), {29'd0, shiftHeld, ctrlHeld, capsLock},
            {29'd0, tbl[i].mods});
      scanCodeReady = 1'b0;
      step();
    end
    check("table_drained", exp_q.size(), 0);

    // Fill the FIFO with the consumer stalled.
    keyReady = 1'b0;
    expect_ev(8'h61, 8'h1C, 0, 0); send(8'h1C);
    expect_ev(8'h62, 8'h32, 0, 0); send(8'h32);
    expect_ev(8'h63, 8'h21, 0, 0); send(8'h21);
    expect_ev(8'h64, 8'h23, 0, 0); send(8'h23);
    check("full_no_overflow", overflow, 0);
    check("full_valid", keyValid, 1);
    check("full_head_stable", keyCode, 8'h1C);

    // Push while full with a pop in the same cycle: both take effect.
    expect_ev(8'h65, 8'h24, 0, 0);
    scanCode = 8'h24; scanCodeReady = 1'b1; keyReady = 1'b1;
    consume();
    @(posedge clk); #1;
    keyReady = 1'b0; scanCodeReady = 1'b0;
    check("push_pop_full_overflow", overflow, 0);
    check("push_pop_full_head", keyCode, 8'h32);
    step();

    // Push while full without a pop: dropped, sticky overflow.
    send(8'h2B);
    check("overflow_set", overflow, 1);
    check("overflow_head_kept", keyCode, 8'h32);
    send(8'h1C);  // second drop, still full
    check("overflow_sticky", overflow, 1);

    // Drain: remaining entries must be 32, 21, 23, 24 with no bubbles.
    keyReady = 1'b1;
    consume();
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_complete", exp_q.size(), 0);
    step();
    check("drain_empty", keyValid, 0);

    // Reset in the middle of an E0 sequence.
    send(8'hE0);
    rst = 1'b0;
    step(); step();
    check("midreset_overflow_clr", overflow, 0);
    check("midreset_empty", keyValid, 0);
    rst = 1'b1;
    step();
    n0 = seen;
    expect_ev(8'h31, 8'h16, 0, 0);
    send(8'h16);
    check("post_reset_event", seen - n0, 1);
    check("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
